pulse_generator: RTL and testbench

Transmit-side counterpart of the readout sampler. On `start` it emits a fixed-length burst of I/Q DAC samples, five lanes per `clk100` cycle (500 MS/s), carrying a carrier at the modulation frequency encoded by an externally supplied phase LUT (phase unit = 2π/50). It sits between the pulse-sequencing control logic and the DAC lane interface, and is the drive tone whose echo the sampler later demodulates.

---
 rtl/qubit_pkg.sv | 44 ++++
 rtl/trig_lut50.sv | 78 +++++++
 rtl/pulse_generator.sv | 161 ++++++++++++++++
 tb/tb_pulse_generator.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/qubit_pkg.sv
// Shared types, constants and arithmetic helpers for the qubit drive path.
// Lane 0 is the earliest sample of each 10 ns cycle.
package qubit_pkg;

  localparam int NUM_LANES   = 5;
  localparam int PHASE_STEPS = 50;
  localparam int LUT_ROWS    = 10;
  localparam int SAMPLE_W    = 16;

  typedef logic [NUM_LANES-1:0][SAMPLE_W-1:0] lane_data_t;
  typedef logic [NUM_LANES-1:0][LUT_ROWS-1:0][5:0] phase_lut_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } pg_state_t;

  function automatic logic [5:0] add_mod50(
    input logic [5:0] a,
    input logic [5:0] b
  );
    logic [6:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 7'(PHASE_STEPS))
      s = s - 7'(PHASE_STEPS);
    return s[5:0];
  endfunction

  // Floor-shifted Q1.15 product; |a*t| < 2^30 so bits [30:15] never wrap.
  function automatic logic [15:0] mul_q15(
    input logic [14:0]        a,
    input logic signed [15:0] t
  );
    logic signed [31:0] ae;
    logic signed [31:0] te;
    logic signed [31:0] p;
    ae = 32'(signed'({1'b0, a}));
    te = 32'(t);
    p  = ae * te;
    return p[30:15];
  endfunction

endpackage

// File: rtl/trig_lut50.sv
// Registered Q1.15 cos/sin for phase p in units of 2*pi/50.
// Phases 50..63 yield zero on both outputs.
module trig_lut50
  import qubit_pkg::*;
(
  input  logic               clk100,
  input  logic               reset,
  input  logic [5:0]         phase,
  output logic signed [15:0] cos_q,
  output logic signed [15:0] sin_q
);

  // round(32767*cos(k*3.6 deg)), k = 0..25
  function automatic logic [15:0] c_tab(input logic [4:0] k);
    logic [15:0] v;
    v = '0;
    case (k)
      5'd0:  v = 16'd32767;
      5'd1:  v = 16'd32702;
      5'd2:  v = 16'd32509;
      5'd3:  v = 16'd32187;
      5'd4:  v = 16'd31738;
      5'd5:  v = 16'd31163;
      5'd6:  v = 16'd30466;
      5'd7:  v = 16'd29648;
      5'd8:  v = 16'd28714;
      5'd9:  v = 16'd27666;
      5'd10: v = 16'd26509;
      5'd11: v = 16'd25247;
      5'd12: v = 16'd23886;
      5'd13: v = 16'd22431;
      5'd14: v = 16'd20886;
      5'd15: v = 16'd19260;
      5'd16: v = 16'd17557;
      5'd17: v = 16'd15786;
      5'd18: v = 16'd13952;
      5'd19: v = 16'd12062;
      5'd20: v = 16'd10126;
      5'd21: v = 16'd8149;
      5'd22: v = 16'd6140;
      5'd23: v = 16'd4107;
      5'd24: v = 16'd2057;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  // Angle a in 3.6 deg units (0..99), folded onto the first quadrant.
  function automatic logic signed [15:0] cos_a(input logic [6:0] a);
    logic [6:0] f;
    f = (a > 7'd50) ? 7'd100 - a : a;
    if (f > 7'd25)
      return -$signed(c_tab(5'(7'd50 - f)));
    return $signed(c_tab(f[4:0]));
  endfunction

  logic [6:0] a_cos;
  logic [7:0] a_t;
  logic [6:0] a_sin;

  assign a_cos = {phase, 1'b0};
  assign a_t   = {1'b0, a_cos} + 8'd75;
  assign a_sin = 7'((a_t >= 8'd100) ? a_t - 8'd100 : a_t);

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      cos_q <= '0;
      sin_q <= '0;
    end else if (phase >= 6'(PHASE_STEPS)) begin
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      cos_q <= cos_a(a_cos);
      sin_q <= cos_a(a_sin);
    end
  end

endmodule

// File: rtl/pulse_generator.sv
// Five-lane I/Q drive-tone burst generator with a three-stage sample pipe.
// Define PULSE_PHASE_OFFSET_EN to add phase_offset (mod 50) to the LUT phase.
module pulse_generator
  import qubit_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] amplitude,
  input  logic [10:0] pulse_length,
  input  logic [5:0]  phase_offset,
  input  phase_lut_t  mod_mod50_LUT,
  output lane_data_t  dac_i_out,
  output lane_data_t  dac_q_out,
  output logic        dac_valid,
  output logic        busy,
  output logic        done
);

  pg_state_t   state, state_n;
  logic [10:0] cyc, cyc_n, len;
  logic [3:0]  lidx, lidx_n;
  logic [1:0]  dcnt, dcnt_n;
  logic [14:0] amp;
  logic        done_q, done_n;
  logic        load, issue;

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    lidx_n  = lidx;
    dcnt_n  = dcnt;
    done_n  = 1'b0;
    load    = 1'b0;
    issue   = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (start && !done_q) begin
          load    = 1'b1;
          cyc_n   = '0;
          lidx_n  = '0;
          dcnt_n  = '0;
          state_n = (pulse_length != '0) ? RUN : DRAIN;
        end
      end
      (state == RUN): begin
        issue  = 1'b1;
        cyc_n  = cyc + 11'd1;
        lidx_n = (lidx == 4'(LUT_ROWS - 1)) ? '0 : lidx + 4'd1;
        if (cyc == len - 11'd1) begin
          state_n = DRAIN;
          dcnt_n  = '0;
        end
      end
      (state == DRAIN): begin
        dcnt_n = dcnt + 2'd1;
        if (dcnt == 2'(LATENCY - 1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cyc    <= '0;
      lidx   <= '0;
      dcnt   <= '0;
      done_q <= 1'b0;
      len    <= '0;
      amp    <= '0;
    end else begin
      state  <= state_n;
      cyc    <= cyc_n;
      lidx   <= lidx_n;
      dcnt   <= dcnt_n;
      done_q <= done_n;
      if (load) begin
        len <= pulse_length;
        amp <= amplitude;
      end
    end
  end

  logic [NUM_LANES-1:0][5:0] ph_d, ph1;
  logic                      iss1, iss2;

`ifdef PULSE_PHASE_OFFSET_EN
  logic [5:0] off;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset)
      off <= '0;
    else if (load)
      off <= phase_offset;
  end

  always_comb begin
    ph_d = '0;
    for (int l = 0; l < NUM_LANES; l++)
      ph_d[l] = add_mod50(mod_mod50_LUT[l][lidx], off);
  end
`else
  logic unused_offset;
  assign unused_offset = ^phase_offset;

  always_comb begin
    ph_d = '0;
    for (int l = 0; l < NUM_LANES; l++)
      ph_d[l] = mod_mod50_LUT[l][lidx];
  end
`endif

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      ph1  <= '0;
      iss1 <= 1'b0;
      iss2 <= 1'b0;
    end else begin
      ph1  <= ph_d;
      iss1 <= issue;
      iss2 <= iss1;
    end
  end

  logic signed [15:0] cos2 [NUM_LANES];
  logic signed [15:0] sin2 [NUM_LANES];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    trig_lut50 u_trig (
      .clk100 (clk100),
      .reset  (reset),
      .phase  (ph1[l]),
      .cos_q  (cos2[l]),
      .sin_q  (sin2[l])
    );
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      dac_i_out <= '0;
      dac_q_out <= '0;
      dac_valid <= 1'b0;
    end else begin
      dac_valid <= iss2;
      for (int l = 0; l < NUM_LANES; l++) begin
        dac_i_out[l] <= iss2 ? mul_q15(amp, cos2[l]) : '0;
        dac_q_out[l] <= iss2 ? mul_q15(amp, sin2[l]) : '0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Randomized bench for pulse_generator against a math-level burst model.
// Honours PULSE_PHASE_OFFSET_EN the same way the design does.
module tb_pulse_generator;
  import qubit_pkg::*;

`ifdef PULSE_PHASE_OFFSET_EN
  localparam bit OFF_EN = 1'b1;
`else
  localparam bit OFF_EN = 1'b0;
`endif

  logic        clk100 = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] amplitude;
  logic [10:0] pulse_length;
  logic [5:0]  phase_offset;
  phase_lut_t  lut;
  lane_data_t  dac_i_out;
  lane_data_t  dac_q_out;
  logic        dac_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk100 = ~clk100;

  pulse_generator #(.LATENCY(3)) dut (
    .clk100        (clk100),
    .reset         (reset),
    .start         (start),
    .amplitude     (amplitude),
    .pulse_length  (pulse_length),
    .phase_offset  (phase_offset),
    .mod_mod50_LUT (lut),
    .dac_i_out     (dac_i_out),
    .dac_q_out     (dac_q_out),
    .dac_valid     (dac_valid),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(
    input string        tag,
    input logic [191:0] got,
    input logic [191:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic longint trig_ref(input int p, input bit s);
    real a, x;
    if (p >= 50) return 0;
    a = 2.0 * 3.14159265358979323846 * p / 50.0;
    x = 32767.0 * (s ? $sin(a) : $cos(a));
    return (x >= 0.0) ? longint'($rtoi(x + 0.5))
                      : -longint'($rtoi(-x + 0.5));
  endfunction

  function automatic int phase_ref(input int l, input int c, input int off);
    int p;
    p = int'(lut[l][c % 10]) + (OFF_EN ? off : 0);
    if (OFF_EN && p >= 50) p -= 50;
    return p;
  endfunction

  function automatic logic [159:0] exp_data(
    input int amp, input int c, input int off
  );
    lane_data_t ei, eq;
    int p;
    for (int l = 0; l < NUM_LANES; l++) begin
      p = phase_ref(l, c, off);
      ei[l] = 16'((longint'(amp) * trig_ref(p, 1'b0)) >>> 15);
      eq[l] = 16'((longint'(amp) * trig_ref(p, 1'b1)) >>> 15);
    end
    return {ei, eq};
  endfunction

  // Observation n is taken at the falling edge after edge k+n.
  task automatic run_burst(
    input string tag, input int amp, input int len,
    input int off, input bit rep
  );
    bit b, v, d;
    logic [159:0] ed;
    @(negedge clk100);
    amplitude    = 15'(amp);
    pulse_length = 11'(len);
    phase_offset = 6'(off);
    start        = 1'b1;
    @(negedge clk100);
    start        = 1'b0;
    amplitude    = 15'($urandom);
    pulse_length = 11'($urandom);
    phase_offset = 6'($urandom);
    for (int n = 0; n <= len + 5; n++) begin
      b  = (n < 3 + len);
      v  = (n >= 3) && (n < 3 + len);
      d  = (n == 3 + len);
      ed = v ? exp_data(amp, n - 3, off) : '0;
      chk({tag, "_stat"}, 192'({busy, dac_valid, done}), 192'({b, v, d}));
      chk({tag, "_data"}, 192'({dac_i_out, dac_q_out}), 192'(ed));
      start = rep && ((n == 1) || (n == 3 + len));
      @(negedge clk100);
    end
    start = 1'b0;
  endtask

  task automatic fill_rand(input int hi);
    for (int l = 0; l < NUM_LANES; l++)
      for (int r = 0; r < LUT_ROWS; r++)
        lut[l][r] = 6'($urandom_range(0, hi));
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    amplitude    = '0;
    pulse_length = '0;
    phase_offset = '0;
    lut          = '0;
    repeat (3) @(negedge clk100);
    chk("rst_stat", 192'({busy, dac_valid, done}), 192'(0));
    chk("rst_data", 192'({dac_i_out, dac_q_out}), 192'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk100);

    run_burst("dc", 16384, 4, 0, 1'b0);

    for (int l = 0; l < NUM_LANES; l++)
      for (int r = 0; r < LUT_ROWS; r++)
        lut[l][r] = 6'(25 * ((5 * r + l) % 2));
    run_burst("f25", 16384, 12, 0, 1'b0);

    fill_rand(49);
    run_burst("len0", 20000, 0, 7, 1'b1);

    fill_rand(49);
    run_burst("rep", 12345, 7, 3, 1'b1);

    for (int t = 0; t < 6; t++) begin
      fill_rand(63);
      run_burst("rnd", int'($urandom_range(0, 32767)),
                int'($urandom_range(1, 40)),
                int'($urandom_range(0, 49)), 1'($urandom));
    end

    fill_rand(49);
    run_burst("max", 32767, 2047, 11, 1'b0);

    fill_rand(49);
    @(negedge clk100);
    amplitude    = 15'd9000;
    pulse_length = 11'd100;
    start        = 1'b1;
    @(negedge clk100);
    start = 1'b0;
    repeat (43) @(negedge clk100);
    reset = 1'b1;
    #1;
    chk("mid_rst_stat", 192'({busy, dac_valid, done}), 192'(0));
    chk("mid_rst_data", 192'({dac_i_out, dac_q_out}), 192'(0));
    @(negedge clk100);
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk100);
      chk("post_rst", 192'({busy, dac_valid, done}), 192'(0));
    end
    run_burst("after_rst", 16384, 9, 0, 1'b0);

    if (OFF_EN) begin
      for (int l = 0; l < NUM_LANES; l++)
        for (int r = 0; r < LUT_ROWS; r++)
          lut[l][r] = 6'd45;
      run_burst("offs", 16384, 6, 10, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
